// File: rtl/dma_read_arbiter.sv
// Round-robin arbiter that shares one DMA read channel among NUM_CLIENTS requesters.
// An in-order tag FIFO records who was granted each command and steers returning data back to that client.
module dma_read_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int WIDTH       = 512,
    parameter int TAG_DEPTH   = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_CLIENTS-1:0]         client_cmd_valid,
    output logic [NUM_CLIENTS-1:0]         client_cmd_ready,
    input  logic [64*NUM_CLIENTS-1:0]      client_cmd_address,
    input  logic [32*NUM_CLIENTS-1:0]      client_cmd_length,
    output logic [NUM_CLIENTS-1:0]         client_data_valid,
    input  logic [NUM_CLIENTS-1:0]         client_data_ready,
    output logic [WIDTH-1:0]               client_data_data,
    output logic                           client_data_last,
    output logic                           read_cmd_valid,
    input  logic                           read_cmd_ready,
    output logic [63:0]                    read_cmd_address,
    output logic [31:0]                    read_cmd_length,
    input  logic                           read_data_valid,
    output logic                           read_data_ready,
    input  logic [WIDTH-1:0]               read_data_data,
    input  logic                           read_data_last,
    output logic [$clog2(TAG_DEPTH):0]     outstanding
);
    localparam int IDX_W = $clog2(NUM_CLIENTS);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] held_q, held_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] tag_mem_q [TAG_DEPTH];

    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] head_tag;
    logic             tag_full;
    logic             tag_empty;
    logic             push;
    logic             pop;

    assign tag_full  = (count_q == CNT_W'(TAG_DEPTH));
    assign tag_empty = (count_q == '0);
    assign head_tag  = tag_mem_q[rd_ptr_q];

    // Round-robin pick; a stalled command keeps its client so the offered fields stay stable.
    always_comb begin
        int cand;
        sel_idx = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            cand = (int'(last_grant_q) + 1 + k) % NUM_CLIENTS;
            if (client_cmd_valid[cand]) sel_idx = IDX_W'(cand);
        end
        if (lock_q && client_cmd_valid[held_q]) sel_idx = held_q;
    end

    always_comb begin
        read_cmd_valid   = (|client_cmd_valid) && !tag_full;
        read_cmd_address = client_cmd_address[64*sel_idx +: 64];
        read_cmd_length  = client_cmd_length[32*sel_idx +: 32];
        client_cmd_ready = '0;
        if (read_cmd_ready && !tag_full && client_cmd_valid[sel_idx])
            client_cmd_ready[sel_idx] = 1'b1;
        push = read_cmd_valid && read_cmd_ready;
    end

    always_comb begin
        client_data_data  = read_data_data;
        client_data_last  = read_data_last;
        client_data_valid = '0;
        read_data_ready   = 1'b0;
        if (!tag_empty) begin
            client_data_valid[head_tag] = read_data_valid;
            read_data_ready             = client_data_ready[head_tag];
        end
        pop = read_data_valid && read_data_ready && read_data_last;
    end

    always_comb begin
        last_grant_d = push ? sel_idx : last_grant_q;
        lock_d       = read_cmd_valid && !read_cmd_ready;
        held_d       = sel_idx;
        wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d      = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= IDX_W'(NUM_CLIENTS - 1);
            lock_q       <= 1'b0;
            held_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            held_q       <= held_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Tag storage holds data only; occupancy is tracked by the reset pointers/count.
    always_ff @(posedge clock) begin
        if (push) tag_mem_q[wr_ptr_q] <= sel_idx;
    end

    assign outstanding = count_q;
endmodule

// File: tb/tb_dma_read_arbiter.sv
// Directed bench for dma_read_arbiter: arbitration, in-order data routing, full/stall and reset behaviour.
module tb_dma_read_arbiter;
    localparam int NC = 4;
    localparam int W  = 512;
    localparam int TD = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [NC-1:0]   client_cmd_valid = '0;
    logic [NC-1:0]   client_cmd_ready;
    logic [64*NC-1:0] client_cmd_address;
    logic [32*NC-1:0] client_cmd_length = '0;
    logic [NC-1:0]   client_data_valid;
    logic [NC-1:0]   client_data_ready = '0;
    logic [W-1:0]    client_data_data;
    logic            client_data_last;
    logic            read_cmd_valid;
    logic            read_cmd_ready = 1'b0;
    logic [63:0]     read_cmd_address;
    logic [31:0]     read_cmd_length;
    logic            read_data_valid = 1'b0;
    logic            read_data_ready;
    logic [W-1:0]    read_data_data = '0;
    logic            read_data_last = 1'b0;
    logic [$clog2(TD):0] outstanding;

    int checks = 0;
    int errors = 0;

    dma_read_arbiter #(.NUM_CLIENTS(NC), .WIDTH(W), .TAG_DEPTH(TD)) dut (
        .clock(clock), .reset(reset),
        .client_cmd_valid(client_cmd_valid), .client_cmd_ready(client_cmd_ready),
        .client_cmd_address(client_cmd_address), .client_cmd_length(client_cmd_length),
        .client_data_valid(client_data_valid), .client_data_ready(client_data_ready),
        .client_data_data(client_data_data), .client_data_last(client_data_last),
        .read_cmd_valid(read_cmd_valid), .read_cmd_ready(read_cmd_ready),
        .read_cmd_address(read_cmd_address), .read_cmd_length(read_cmd_length),
        .read_data_valid(read_data_valid), .read_data_ready(read_data_ready),
        .read_data_data(read_data_data), .read_data_last(read_data_last),
        .outstanding(outstanding)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        client_cmd_address = {64'h4000, 64'h3000, 64'h2000, 64'h1000};
        read_data_data = {8{64'hA5A5_0123_4567_89AB}};

        // Reset state
        #1 reset = 1'b1;
        tick();
        #1;
        check("rst_cmd_ready", 64'(client_cmd_ready), 64'h0);
        check("rst_cmd_valid", 64'(read_cmd_valid), 64'h0);
        check("rst_data_ready", 64'(read_data_ready), 64'h0);
        check("rst_data_valid", 64'(client_data_valid), 64'h0);
        check("rst_outstanding", 64'(outstanding), 64'h0);
        reset = 1'b0;
        tick();

        // Round-robin with all clients requesting
        client_cmd_valid = 4'hF;
        read_cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_grant", 64'(client_cmd_ready), 64'(1 << k));
            check("rr_addr", read_cmd_address, 64'h1000 * (k + 1));
            tick();
        end
        #1;
        check("rr_outstanding4", 64'(outstanding), 64'd4);
        check("rr_wrap_grant", 64'(client_cmd_ready), 64'h1);
        client_cmd_valid = '0;
        read_cmd_ready = 1'b0;

        // In-order return to clients 0..3, no bubbles
        client_data_ready = 4'hF;
        read_data_valid = 1'b1;
        read_data_last = 1'b1;
        #1;
        check("data_bcast", client_data_data[63:0], 64'hA5A5_0123_4567_89AB);
        check("last_bcast", 64'(client_data_last), 64'h1);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("ret_valid", 64'(client_data_valid), 64'(1 << k));
            check("ret_ready", 64'(read_data_ready), 64'h1);
            tick();
        end
        #1;
        check("drain_outstanding", 64'(outstanding), 64'h0);
        check("empty_data_ready", 64'(read_data_ready), 64'h0);
        check("empty_data_valid", 64'(client_data_valid), 64'h0);
        read_data_valid = 1'b0;

        // Client 2: 128 B (two beats), then client 0: 64 B (one beat)
        client_cmd_length = {32'd0, 32'd128, 32'd0, 32'd64};
        client_cmd_valid = 4'b0100;
        read_cmd_ready = 1'b1;
        #1;
        check("c2_grant", 64'(client_cmd_ready), 64'h4);
        check("c2_len", 64'(read_cmd_length), 64'd128);
        tick();
        client_cmd_valid = 4'b0001;
        #1;
        check("c0_grant", 64'(client_cmd_ready), 64'h1);
        check("c0_len", 64'(read_cmd_length), 64'd64);
        tick();
        client_cmd_valid = '0;
        #1;
        check("two_outstanding", 64'(outstanding), 64'd2);
        read_data_valid = 1'b1;
        read_data_last = 1'b0;
        #1;
        check("c2_beat1", 64'(client_data_valid), 64'h4);
        tick();
        read_data_last = 1'b1;
        #1;
        check("c2_beat2", 64'(client_data_valid), 64'h4);
        check("c2_nopop", 64'(outstanding), 64'd2);
        tick();
        #1;
        check("c0_beat", 64'(client_data_valid), 64'h1);
        check("c0_outstanding", 64'(outstanding), 64'd1);
        tick();
        read_data_valid = 1'b0;
        #1;
        check("c2c0_drained", 64'(outstanding), 64'd0);

        // Backpressure from the head client
        client_cmd_valid = 4'b0010;
        #1;
        check("c1_grant", 64'(client_cmd_ready), 64'h2);
        tick();
        client_cmd_valid = '0;
        client_data_ready = '0;
        read_data_valid = 1'b1;
        #1;
        check("bp_data_ready", 64'(read_data_ready), 64'h0);
        check("bp_data_valid", 64'(client_data_valid), 64'h2);
        tick();
        #1;
        check("bp_held", 64'(outstanding), 64'd1);
        client_data_ready = 4'b0010;
        #1;
        check("bp_release", 64'(read_data_ready), 64'h1);
        tick();
        read_data_valid = 1'b0;
        client_data_ready = 4'hF;
        #1;
        check("bp_drained", 64'(outstanding), 64'd0);

        // Stalled command keeps its client even when a higher-priority one appears
        read_cmd_ready = 1'b0;
        client_cmd_valid = 4'b0001;
        #1;
        check("stall_valid", 64'(read_cmd_valid), 64'h1);
        check("stall_ready", 64'(client_cmd_ready), 64'h0);
        tick();
        client_cmd_valid = 4'b0101;
        #1;
        check("stall_hold_addr", read_cmd_address, 64'h1000);
        read_cmd_ready = 1'b1;
        #1;
        check("stall_grant", 64'(client_cmd_ready), 64'h1);
        tick();
        client_cmd_valid = '0;
        read_data_valid = 1'b1;
        #1;
        check("stall_ret", 64'(client_data_valid), 64'h1);
        tick();
        read_data_valid = 1'b0;

        // Fill the tag FIFO
        client_cmd_valid = 4'hF;
        repeat (16) tick();
        #1;
        check("full_outstanding", 64'(outstanding), 64'd16);
        check("full_cmd_valid", 64'(read_cmd_valid), 64'h0);
        check("full_cmd_ready", 64'(client_cmd_ready), 64'h0);
        read_data_valid = 1'b1;
        #1;
        check("full_head", 64'(client_data_valid), 64'h2);
        check("full_pop_blocks", 64'(read_cmd_valid), 64'h0);
        tick();
        #1;
        check("unfull_outstanding", 64'(outstanding), 64'd15);
        check("unfull_cmd_valid", 64'(read_cmd_valid), 64'h1);
        check("unfull_grant", 64'(client_cmd_ready), 64'h2);
        client_cmd_valid = '0;
        repeat (10) tick();
        #1;
        check("five_outstanding", 64'(outstanding), 64'd5);
        check("five_head", 64'(client_data_valid), 64'h1);

        // Simultaneous push and pop at occupancy 5
        client_cmd_valid = 4'b1000;
        #1;
        check("pp_grant", 64'(client_cmd_ready), 64'h8);
        tick();
        client_cmd_valid = '0;
        #1;
        check("pp_outstanding", 64'(outstanding), 64'd5);
        check("pp_head", 64'(client_data_valid), 64'h2);
        tick();
        tick();
        #1;
        check("three_outstanding", 64'(outstanding), 64'd3);
        check("three_head", 64'(client_data_valid), 64'h8);

        // Asynchronous reset with tags outstanding
        reset = 1'b1;
        #1;
        check("arst_outstanding", 64'(outstanding), 64'd0);
        check("arst_data_ready", 64'(read_data_ready), 64'h0);
        check("arst_data_valid", 64'(client_data_valid), 64'h0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_data_ready", 64'(read_data_ready), 64'h0);
        tick();
        read_data_valid = 1'b0;
        client_cmd_valid = 4'hF;
        #1;
        check("post_rst_grant", 64'(client_cmd_ready), 64'h1);
        check("post_rst_outstanding", 64'(outstanding), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
